apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB slave: converts a simple valid/ready command stream into APB SETUP/ACCESS transfers on the APB bus signals, and returns one response per command.
- Drives PADDR/PSELx/PWRITE/PWDATA/PENABLE and samples PREADY/PRDATA.
- Supports one outstanding transfer and is the bus owner for a single slave.

Parameters:
ADDR_WIDTH, 16, APB address width (matches bus PADDR).
DATA_WIDTH, 32, APB data width (matches PWDATA/PRDATA).
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN; legal range >= 1.

Ports:
PCLK  input  1  bus clock; all logic on rising edge
PRESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  bridge accepts command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_write  output  1  echo of cmd_write for this response
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_timeout  output  1  transfer aborted by watchdog
PADDR  output  ADDR_WIDTH  APB address
PSELx  output  1  APB select
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PENABLE  output  1  APB enable
PREADY  input  1  slave ready
PRDATA  input  DATA_WIDTH  slave read data

Behaviour:
- Interface decided: one clock PCLK; reset PRESET is synchronous and active-high. The bridge does not drive the bus PRESETn.
- All outputs are registered except cmd_ready, which is decoded from the state.
- Reset values: state IDLE; PSELx=0; PENABLE=0; PADDR=0; PWRITE=0; PWDATA=0; rsp_valid=0; rsp_write=0; rsp_rdata=0; rsp_timeout=0.
- cmd_ready=1 only in IDLE and not in reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if cmd_valid, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, set PSELx=1, go to SETUP.
  - SETUP: exactly 1 cycle with PSELx=1, PENABLE=0. Set PENABLE=1 and go to ACCESS.
  - ACCESS (PSELx=1, PENABLE=1), evaluated each cycle:
    - PREADY=1: rsp_rdata = PWRITE ? 0 : PRDATA, rsp_write=PWRITE, rsp_timeout=0, rsp_valid=1. Clear PSELx and PENABLE. Go to RESP.
    - PREADY=0: stay in ACCESS. Wait states are unbounded unless APB_TIMEOUT_EN is defined.
  - RESP: rsp_valid held with data stable until rsp_ready=1. On that cycle clear rsp_valid and go to IDLE.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the final ACCESS cycle, then hold their last value until the next accept. No toggling while idle.
- Zero-wait throughput: accept(IDLE) -> SETUP -> ACCESS -> RESP -> IDLE, i.e. 4 cycles per command with rsp_ready=1. The next accept occurs in the cycle after the response handshake.
- cmd_valid while not in IDLE is ignored; the command is not consumed.
- PREADY/PRDATA are ignored outside ACCESS.
- Reset in any state, including mid-ACCESS: on the next edge everything returns to reset values. The in-flight command is dropped and no response is produced.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined: a wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts: PSELx/PENABLE cleared, rsp_valid=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - PREADY=1 in that same cycle takes priority and completes the transfer normally.
- Undefined: no counter is built; ACCESS waits indefinitely; the rsp_timeout port remains and is tied to 0.

Test Plan:
- Write, zero wait: cmd 0x0010/0xDEADBEEF, PREADY=1 -> PSELx=1 for 2 cycles, PENABLE only in the 2nd; PWDATA=0xDEADBEEF both cycles; rsp_valid next cycle with rsp_write=1, rsp_rdata=0.
- Read, 3 wait states: addr 0x0044; PREADY low for 3 ACCESS cycles, then high with PRDATA=0xCAFEF00D -> ACCESS lasts 4 cycles, PADDR stays 0x0044, rsp_rdata=0xCAFEF00D.
- Response backpressure: rsp_ready low for 5 cycles with cmd_valid high -> rsp_valid and data held, cmd_ready=0, PSELx stays 0. The next accept occurs in the cycle after rsp_ready rises.
- Reset mid-ACCESS: PRESET=1 for one cycle during wait states -> next cycle PSELx=0, PENABLE=0, rsp_valid=0, cmd_ready=1; no response for the dropped command.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - PREADY held low -> after the 16th ACCESS cycle rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 in the 16th cycle and PRDATA=0x12345678 -> normal completion, rsp_timeout=0, rsp_rdata=0x12345678.
- Back-to-back: 3 queued reads to addrs 0x0, 0x4, 0x8 with zero wait and rsp_ready=1 -> exactly 3 responses, 4 cycles apart, in order, with matching PRDATA.

Source files
------------

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers for a
// single slave and returns one response per command. At most one transfer is
// in flight at a time.
//
// Optional feature macro: APB_TIMEOUT_EN
//   Defined   : ACCESS-phase watchdog aborts a transfer whose PREADY stays low
//               for TIMEOUT_CYCLES ACCESS cycles (rsp_timeout=1, rsp_rdata=0).
//   Undefined : ACCESS waits indefinitely; rsp_timeout is tied to 0.
//
// Ports
//   PCLK        in   bus clock, all logic on the rising edge
//   PRESET      in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  command accepted (IDLE and not in reset)
//   cmd_write   in   1=write, 0=read
//   cmd_addr    in   [ADDR_WIDTH] transfer address
//   cmd_wdata   in   [DATA_WIDTH] write data
//   rsp_valid   out  response present
//   rsp_ready   in   consumer accepts response
//   rsp_write   out  direction of the command this response belongs to
//   rsp_rdata   out  [DATA_WIDTH] read data, 0 for writes and timeouts
//   rsp_timeout out  transfer aborted by the watchdog
//   PADDR       out  [ADDR_WIDTH] APB address
//   PSELx       out  APB select
//   PWRITE      out  APB direction
//   PWDATA      out  [DATA_WIDTH] APB write data
//   PENABLE     out  APB enable
//   PREADY      in   slave ready
//   PRDATA      in   [DATA_WIDTH] slave read data
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_psel;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_penable;
    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  w_timeout_hit;
    logic                  w_access_end;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen during the TIMEOUT_CYCLES-th ACCESS cycle (starts at 0).
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;

    // PREADY=1 in the final allowed cycle still completes normally.
    assign w_timeout_hit = !PREADY && (r_wait_cnt == LAST_WAIT);
    assign rsp_timeout   = r_rsp_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout_hit        = 1'b0;
    assign rsp_timeout          = 1'b0;
`endif

    assign w_access_end = PREADY || w_timeout_hit;

    assign cmd_ready = (r_state == S_IDLE) && !PRESET;
    assign PADDR     = r_paddr;
    assign PSELx     = r_psel;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PENABLE   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid)    w_state_nxt = S_SETUP;
            S_SETUP:                    w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_access_end) w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready)    w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    // Bus address/data only change on accept, so they never
                    // toggle while the bridge sits idle.
                    if (cmd_valid) begin
                        r_paddr  <= cmd_addr;
                        r_pwrite <= cmd_write;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (w_access_end) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_pwrite;
                        // A timeout (PREADY low here) also returns zero data.
                        r_rsp_rdata <= (r_pwrite || !PREADY) ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
                        r_rsp_timeout <= !PREADY;
`endif
                    end
`ifdef APB_TIMEOUT_EN
                    if (!w_access_end) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Scoreboard bench for apb_master_bridge. A stimulus process issues commands
// and pushes both the slave behaviour (wait states, read data) and the expected
// response into queues. An APB slave process replays the behaviour and checks
// the bus, and a consumer/monitor process drives rsp_ready and pops expected
// responses at each response handshake.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] PADDR;
    logic        PSELx;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PREADY;
    logic [31:0] PRDATA;

    apb_master_bridge #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSELx      (PSELx),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        to;
    } rsp_t;

    xfer_t slv_q[$];
    rsp_t  exp_q[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rdy_mode = 1;     // 0 random, 1 always ready, 2 never ready
    bit chk_spacing = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic xfer_t mk(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.wdata = wdata; x.waits = waits; x.rdata = rdata;
        return x;
    endfunction

    // Reference: what the consumer should see for a given transfer.
    function automatic rsp_t model(input xfer_t x);
        rsp_t r;
        r.wr = x.wr;
        r.to = 1'b0;
`ifdef APB_TIMEOUT_EN
        r.to = (x.waits >= TO);
`endif
        r.rdata = (x.wr || r.to) ? 32'h0 : x.rdata;
        return r;
    endfunction

    // Negedges from the SETUP cycle until rsp_valid is first seen.
    function automatic int lat_of(input xfer_t x);
`ifdef APB_TIMEOUT_EN
        if (x.waits >= TO) return TO + 1;
`endif
        return x.waits + 2;
    endfunction

    function automatic xfer_t rand_xfer();
        int w;
        w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
        return mk(1'($urandom_range(0, 1)), 16'($urandom), $urandom, w, $urandom);
    endfunction

    // Called at a negedge; returns at the negedge of the SETUP cycle.
    task automatic issue(input xfer_t x);
        bit done;
        done = 0;
        cmd_write = x.wr;
        cmd_addr  = x.addr;
        cmd_wdata = x.wdata;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (cmd_ready === 1'b1) begin
                slv_q.push_back(x);
                exp_q.push_back(model(x));
                done = 1;
            end
            @(negedge PCLK);
        end
        if (!done) begin
            vectors++; errors++;
            $display("FAIL cmd_accept: got no accept, want accept within 400 cycles");
        end
    endtask

    task automatic wait_rsp(input int lat);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < lat + 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(lat));
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || PSELx !== 1'b0) && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge PCLK);
    endtask

    // APB slave model
    initial begin : slave
        xfer_t cur;
        int    cnt;
        bit    prev_setup;
        bit    in_acc;
        PREADY = 1'b0;
        PRDATA = '0;
        prev_setup = 0;
        in_acc = 0;
        cnt = 0;
        cur = mk(0, 0, 0, 0, 0);
        forever begin
            @(negedge PCLK); #1;
            if (PRESET !== 1'b0) begin
                prev_setup = 0; in_acc = 0; PREADY = 1'b0;
            end else if (PSELx === 1'b1 && PENABLE === 1'b0) begin
                chk("setup_one_cycle", 64'(prev_setup), 64'd0);
                if (slv_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_setup: got SETUP addr %0h, want no transfer", PADDR);
                end else begin
                    cur = slv_q.pop_front();
                    cnt = 0;
                    chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
                    chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
                    chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
                end
                prev_setup = 1; in_acc = 0;
                PREADY = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
            end else if (PSELx === 1'b1 && PENABLE === 1'b1) begin
                chk("access_after_setup", 64'(prev_setup || in_acc), 64'd1);
                chk("access_paddr", 64'(PADDR), 64'(cur.addr));
                chk("access_pwrite", 64'(PWRITE), 64'(cur.wr));
                chk("access_pwdata", 64'(PWDATA), 64'(cur.wdata));
                if (cnt == cur.waits) begin
                    PREADY = 1'b1;
                    PRDATA = cur.rdata;
                end else begin
                    PREADY = 1'b0;
                    PRDATA = $urandom;
                end
                cnt++;
                prev_setup = 0; in_acc = 1;
            end else begin
                chk("setup_then_access", 64'(prev_setup), 64'd0);
                chk("penable_idle", 64'(PENABLE), 64'd0);
                prev_setup = 0; in_acc = 0;
                PREADY = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
            end
        end
    end

    // Response consumer and scoreboard monitor
    initial begin : monitor
        rsp_t e;
        rsp_t h;
        bit   held;
        bit   r;
        int   prev_hs;
        rsp_ready = 1'b0;
        held = 0;
        prev_hs = -1;
        h.wr = 0; h.rdata = 0; h.to = 0;
        forever begin
            @(negedge PCLK); #1;
            case (rdy_mode)
                0:       r = ($urandom_range(0, 3) != 0);
                1:       r = 1'b1;
                default: r = 1'b0;
            endcase
            rsp_ready = r;
            if (PRESET !== 1'b0) begin
                held = 0;
            end else if (rsp_valid === 1'b1) begin
                if (held) begin
                    chk("rsp_hold_write", 64'(rsp_write), 64'(h.wr));
                    chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(h.rdata));
                    chk("rsp_hold_timeout", 64'(rsp_timeout), 64'(h.to));
                end
                if (r) begin
                    if (exp_q.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL rsp_unexpected: got response rdata %0h, want none", rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    end
                    if (chk_spacing) begin
                        if (prev_hs >= 0) chk("rsp_spacing", 64'(cyc - prev_hs), 64'd4);
                        prev_hs = cyc;
                    end else begin
                        prev_hs = -1;
                    end
                    held = 0;
                end else begin
                    held = 1;
                    h.wr = rsp_write; h.rdata = rsp_rdata; h.to = rsp_timeout;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000ns");
        $fatal(1, "bench did not finish");
    end

    // Stimulus
    initial begin : stim
        xfer_t x;
        xfer_t x2;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        chk("reset_psel", 64'(PSELx), 64'd0);
        chk("reset_penable", 64'(PENABLE), 64'd0);
        chk("reset_paddr", 64'(PADDR), 64'd0);
        chk("reset_pwrite", 64'(PWRITE), 64'd0);
        chk("reset_pwdata", 64'(PWDATA), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_write", 64'(rsp_write), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
        PRESET = 1'b0;
        #1;
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Zero-wait write
        rdy_mode = 1;
        @(negedge PCLK);
        x = mk(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h5555AAAA);
        issue(x);
        cmd_valid = 1'b0;
        wait_rsp(lat_of(x));
        drain();

        // Read with 3 wait states
        x = mk(1'b0, 16'h0044, $urandom, 3, 32'hCAFEF00D);
        issue(x);
        cmd_valid = 1'b0;
        wait_rsp(lat_of(x));
        drain();

`ifdef APB_TIMEOUT_EN
        // Watchdog abort, then completion in the last allowed cycle
        x = mk(1'b0, 16'h0100, $urandom, TO, 32'hA5A5A5A5);
        issue(x);
        cmd_valid = 1'b0;
        wait_rsp(lat_of(x));
        drain();
        x = mk(1'b0, 16'h0104, $urandom, TO - 1, 32'h12345678);
        issue(x);
        cmd_valid = 1'b0;
        wait_rsp(lat_of(x));
        drain();
`else
        // Long wait with no watchdog
        x = mk(1'b0, 16'h0100, $urandom, 20, 32'h12345678);
        issue(x);
        cmd_valid = 1'b0;
        wait_rsp(lat_of(x));
        drain();
`endif

        // Response backpressure with the next command already waiting
        rdy_mode = 2;
        repeat (2) @(negedge PCLK);
        x  = mk(1'b1, 16'h0200, 32'h0BADF00D, 0, $urandom);
        x2 = mk(1'b0, 16'h0204, 32'h11112222, 1, 32'h33334444);
        issue(x);
        cmd_write = x2.wr; cmd_addr = x2.addr; cmd_wdata = x2.wdata; cmd_valid = 1'b1;
        wait_rsp(lat_of(x));
        repeat (5) begin
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_psel", 64'(PSELx), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            @(negedge PCLK);
        end
        rdy_mode = 1;
        chk("bp_cmd_ready_before", 64'(cmd_ready), 64'd0);
        @(negedge PCLK);
        chk("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);
        issue(x2);
        drain();

        // Back-to-back zero-wait reads
        chk_spacing = 1;
        repeat (2) @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            issue(mk(1'b0, 16'(i * 4), $urandom, 0, $urandom));
        end
        drain();
        chk_spacing = 0;

        // Reset while waiting in ACCESS
        x = mk(1'b0, 16'h0080, $urandom, 8, $urandom);
        issue(x);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_access_penable", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        #1;
        chk("mid_reset_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge PCLK);
        chk("mid_reset_psel", 64'(PSELx), 64'd0);
        chk("mid_reset_penable", 64'(PENABLE), 64'd0);
        chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_reset_paddr", 64'(PADDR), 64'd0);
        PRESET = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("mid_reset_cmd_ready_after", 64'(cmd_ready), 64'd1);
        repeat (20) @(negedge PCLK);

        // Randomized traffic with random backpressure and idle gaps
        rdy_mode = 0;
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                cmd_valid = 1'b0;
                cmd_addr  = 16'($urandom);
                cmd_wdata = $urandom;
                cmd_write = 1'($urandom_range(0, 1));
                repeat (gap) @(negedge PCLK);
            end
            issue(rand_xfer());
        end
        drain();

        chk("final_exp_queue", 64'(exp_q.size()), 64'd0);
        chk("final_slave_queue", 64'(slv_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
